// File: rtl/gray_frame_buffer.sv
// gray_frame_buffer: captures one N x M frame of 8-bit grayscale pixels from the
// grayscaler and replays it in raster order with stall support and a done strobe.
module gray_frame_buffer #(
  parameter int unsigned N  = 2,
  parameter int unsigned M  = 2,
  parameter int unsigned AW = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       FB_enable,
  input  logic       gray_valid,
  input  logic [7:0] Din,
  input  logic       rd_req,
  input  logic       rd_pause,
  output logic [7:0] Dout,
  output logic       Dout_valid,
  output logic       full,
  output logic       overrun,
  output logic       FB_done
);

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = N * M;
  // Memory index width; the address counters may be wider than the store needs.
  localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_FULL,
    S_READ,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            dout_valid_q, dout_valid_d;
  logic            full_q, full_d;
  logic            overrun_q, overrun_d;
  logic            fb_done_q, fb_done_d;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem [DEPTH];

  // Next-state, address counters, write strobe and registered output values.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overrun_d    = overrun_q;
    mem_we       = 1'b0;
    mem_waddr    = wr_addr_q;

    case (state_q)
      S_IDLE: begin
        wr_addr_d = '0;
        rd_addr_d = '0;
        if (FB_enable) begin
          state_d   = S_WRITE;
          overrun_d = 1'b0;
        end
        // A pixel arriving before capture is armed is lost; that wins over the clear.
        if (gray_valid) begin
          overrun_d = 1'b1;
        end
      end

      S_WRITE: begin
        // Restart rewinds to address 0; a pixel in the same cycle lands at 0.
        if (FB_enable) begin
          mem_waddr = '0;
          overrun_d = 1'b0;
        end
        wr_addr_d = mem_waddr;
        if (gray_valid) begin
          mem_we = 1'b1;
          if (mem_waddr == LAST_ADDR) begin
            state_d   = S_FULL;
            wr_addr_d = '0;
          end else begin
            wr_addr_d = mem_waddr + AW'(1);
          end
        end
      end

      S_FULL: begin
        // A new arm discards the held frame and takes priority over replay.
        if (FB_enable) begin
          state_d   = S_WRITE;
          wr_addr_d = '0;
          overrun_d = 1'b0;
        end else if (rd_req) begin
          state_d   = S_READ;
          rd_addr_d = '0;
        end
        if (gray_valid) begin
          overrun_d = 1'b1;
        end
      end

      S_READ: begin
        if (gray_valid) begin
          overrun_d = 1'b1;
        end
        if (!rd_pause) begin
          dout_d       = mem[IW'(rd_addr_q)];
          dout_valid_d = 1'b1;
          if (rd_addr_q == LAST_ADDR) begin
            state_d   = S_DONE;
            rd_addr_d = '0;
          end else begin
            rd_addr_d = rd_addr_q + AW'(1);
          end
        end
      end

      S_DONE: begin
        if (gray_valid) begin
          overrun_d = 1'b1;
        end
        state_d   = S_IDLE;
        wr_addr_d = '0;
        rd_addr_d = '0;
      end

      default: begin
        state_d   = S_IDLE;
        wr_addr_d = '0;
        rd_addr_d = '0;
      end
    endcase

    // Status flags follow the state being entered so they are registered with it.
    full_d    = (state_d == S_FULL);
    fb_done_d = (state_d == S_DONE);
  end

  // State, counters and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      full_q       <= 1'b0;
      overrun_q    <= 1'b0;
      fb_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      full_q       <= full_d;
      overrun_q    <= overrun_d;
      fb_done_q    <= fb_done_d;
    end
  end

  // Frame store write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[IW'(mem_waddr)] <= Din;
    end
  end

  assign Dout       = dout_q;
  assign Dout_valid = dout_valid_q;
  assign full       = full_q;
  assign overrun    = overrun_q;
  assign FB_done    = fb_done_q;

endmodule

// File: tb/tb_gray_frame_buffer.sv
// Self-checking bench for gray_frame_buffer: scoreboard of captured pixels
// compared against the replayed stream, plus flag and timing checks.
module tb_gray_frame_buffer;

  localparam int unsigned N    = 2;
  localparam int unsigned M    = 2;
  localparam int unsigned AW   = 8;
  localparam int unsigned NPIX = N * M;

  logic       clk;
  logic       rst;
  logic       FB_enable;
  logic       gray_valid;
  logic [7:0] Din;
  logic       rd_req;
  logic       rd_pause;
  logic [7:0] Dout;
  logic       Dout_valid;
  logic       full;
  logic       overrun;
  logic       FB_done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  gray_frame_buffer #(.N(N), .M(M), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .FB_enable  (FB_enable),
    .gray_valid (gray_valid),
    .Din        (Din),
    .rd_req     (rd_req),
    .rd_pause   (rd_pause),
    .Dout       (Dout),
    .Dout_valid (Dout_valid),
    .full       (full),
    .overrun    (overrun),
    .FB_done    (FB_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arm a new capture; any earlier partial frame is superseded.
  task automatic arm();
    FB_enable  = 1'b1;
    gray_valid = 1'b0;
    @(negedge clk);
    FB_enable = 1'b0;
    exp_q.delete();
  endtask

  // Drive one pixel for one cycle, record it, then idle for gap cycles.
  task automatic send_pix(input logic [7:0] v, input int gap);
    gray_valid = 1'b1;
    Din        = v;
    exp_q.push_back(v);
    @(negedge clk);
    gray_valid = 1'b0;
    Din        = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  // Arm and capture a full frame; pixel 0 is the most significant byte of px.
  task automatic capture_frame(input string name, input logic [8*NPIX-1:0] px, input int gap);
    logic [7:0] v;
    arm();
    for (int i = 0; i < int'(NPIX); i++) begin
      checks++;
      if (full !== 1'b0) begin
        errors++;
        $display("FAIL %s full_early pix%0d: got %b want 0", name, i, full);
      end
      v = px[8*(int'(NPIX)-1-i) +: 8];
      send_pix(v, (i == int'(NPIX) - 1) ? 0 : gap);
    end
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL %s full_set: got %b want 1", name, full);
    end
  endtask

  // Request replay, optionally stall after the first pixel, and score the stream.
  task automatic replay(input string name, input int stall_len, output int nvalid);
    int stalls;
    int issued;
    bit done;
    logic [7:0] e;
    logic [7:0] held;
    nvalid   = 0;
    stalls   = 0;
    issued   = 0;
    done     = 1'b0;
    held     = 8'h00;
    rd_pause = 1'b0;
    rd_req   = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    checks++;
    if (Dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_too_early: got %b want 0", name, Dout_valid);
    end
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      if (Dout_valid === 1'b1) begin
        if (nvalid == 0) begin
          checks++;
          if (cyc != 1) begin
            errors++;
            $display("FAIL %s first_latency: got cycle %0d want 1", name, cyc);
          end
        end
        nvalid++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s extra_pixel: got %h want none", name, Dout);
        end else begin
          e    = exp_q.pop_front();
          held = e;
          checks++;
          if (Dout !== e) begin
            errors++;
            $display("FAIL %s pixel%0d: got %h want %h", name, nvalid - 1, Dout, e);
          end
          checks++;
          if (FB_done !== 1'(exp_q.size() == 0)) begin
            errors++;
            $display("FAIL %s fb_done_at_pixel%0d: got %b want %b", name, nvalid - 1,
                     FB_done, exp_q.size() == 0);
          end
        end
        if (FB_done === 1'b1) done = 1'b1;
      end else if (nvalid > 0) begin
        stalls++;
        checks++;
        if (Dout !== held) begin
          errors++;
          $display("FAIL %s hold_during_stall: got %h want %h", name, Dout, held);
        end
      end
      if (stall_len > 0 && nvalid >= 1 && issued < stall_len) begin
        rd_pause = 1'b1;
        issued++;
      end else begin
        rd_pause = 1'b0;
      end
    end
    rd_pause = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: got %0d pixels without FB_done want %0d", name, nvalid, NPIX);
    end
    checks++;
    if (stalls != stall_len) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, stall_len);
    end
    @(negedge clk);
    checks++;
    if (Dout_valid !== 1'b0 || FB_done !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got valid=%b done=%b full=%b want 0 0 0", name,
               Dout_valid, FB_done, full);
    end
    checks++;
    if (Dout !== held) begin
      errors++;
      $display("FAIL %s dout_retain: got %h want %h", name, Dout, held);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (Dout !== 8'h00 || Dout_valid !== 1'b0 || full !== 1'b0 || overrun !== 1'b0 ||
        FB_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got dout=%h v=%b full=%b ovr=%b done=%b want all 0",
               Dout, Dout_valid, full, overrun, FB_done);
    end
    rst = 1'b0;
    @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (Dout_valid !== 1'b0 || FB_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_rdreq c%0d: got valid=%b done=%b want 0 0", i,
                 Dout_valid, FB_done);
      end
    end
  endtask

  task automatic test_basic();
    int nv;
    capture_frame("basic", 32'h10203040, 0);
    replay("basic", 0, nv);
    checks++;
    if (nv != int'(NPIX)) begin
      errors++;
      $display("FAIL basic valid_count: got %0d want %0d", nv, NPIX);
    end
  endtask

  task automatic test_gapped();
    int nv;
    capture_frame("gapped", 32'h10203040, 2);
    replay("gapped", 0, nv);
    checks++;
    if (nv != int'(NPIX)) begin
      errors++;
      $display("FAIL gapped valid_count: got %0d want %0d", nv, NPIX);
    end
  endtask

  task automatic test_stall();
    int nv;
    capture_frame("stall", 32'h10203040, 0);
    replay("stall", 3, nv);
    checks++;
    if (nv != int'(NPIX)) begin
      errors++;
      $display("FAIL stall valid_count: got %0d want %0d", nv, NPIX);
    end
  endtask

  task automatic test_overrun();
    int nv;
    arm();
    send_pix(8'h10, 0);
    send_pix(8'h20, 0);
    send_pix(8'h30, 0);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (Dout_valid !== 1'b0 || full !== 1'b0) begin
        errors++;
        $display("FAIL overrun early_rdreq c%0d: got valid=%b full=%b want 0 0", i,
                 Dout_valid, full);
      end
      @(negedge clk);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun clear_in_write: got %b want 0", overrun);
    end
    send_pix(8'h40, 0);
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL overrun full_set: got %b want 1", full);
    end
    gray_valid = 1'b1;
    Din        = 8'hFF;
    @(negedge clk);
    gray_valid = 1'b0;
    Din        = 8'h00;
    checks++;
    if (overrun !== 1'b1 || full !== 1'b1) begin
      errors++;
      $display("FAIL overrun set_in_full: got ovr=%b full=%b want 1 1", overrun, full);
    end
    replay("overrun", 0, nv);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun sticky: got %b want 1", overrun);
    end
    arm();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun cleared_by_enable: got %b want 0", overrun);
    end
  endtask

  task automatic test_restart();
    int nv;
    arm();
    send_pix(8'hAA, 0);
    send_pix(8'hBB, 0);
    // Restart and first new pixel in the same cycle: pixel goes to address 0.
    FB_enable  = 1'b1;
    gray_valid = 1'b1;
    Din        = 8'h01;
    exp_q.delete();
    exp_q.push_back(8'h01);
    @(negedge clk);
    FB_enable  = 1'b0;
    gray_valid = 1'b0;
    send_pix(8'h02, 0);
    send_pix(8'h03, 0);
    checks++;
    if (full !== 1'b0) begin
      errors++;
      $display("FAIL restart full_early: got %b want 0", full);
    end
    send_pix(8'h04, 0);
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL restart full_set: got %b want 1", full);
    end
    replay("restart", 0, nv);
  endtask

  task automatic test_reset_mid_replay();
    int cnt;
    capture_frame("midrst", 32'h10203040, 0);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10 && cnt < 2; i++) begin
      @(negedge clk);
      if (Dout_valid === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 2) begin
      errors++;
      $display("FAIL midrst reach_second_pixel: got %0d want 2", cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (Dout !== 8'h00 || Dout_valid !== 1'b0 || full !== 1'b0 || overrun !== 1'b0 ||
        FB_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst async_clear: got dout=%h v=%b full=%b ovr=%b done=%b want all 0",
               Dout, Dout_valid, full, overrun, FB_done);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (Dout_valid !== 1'b0 || FB_done !== 1'b0 || full !== 1'b0) begin
        errors++;
        $display("FAIL midrst rdreq_ignored c%0d: got valid=%b done=%b full=%b want 0 0 0",
                 i, Dout_valid, FB_done, full);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nv;
    capture_frame("b2b_a", 32'hC0C1C2C3, 0);
    replay("b2b_a", 0, nv);
    capture_frame("b2b_b", 32'h5A00FF7E, 1);
    replay("b2b_b", 1, nv);
    checks++;
    if (nv != int'(NPIX)) begin
      errors++;
      $display("FAIL b2b valid_count: got %0d want %0d", nv, NPIX);
    end
  endtask

  initial begin
    rst        = 1'b1;
    FB_enable  = 1'b0;
    gray_valid = 1'b0;
    Din        = 8'h00;
    rd_req     = 1'b0;
    rd_pause   = 1'b0;
    test_reset();
    test_basic();
    test_gapped();
    test_stall();
    test_overrun();
    test_restart();
    test_reset_mid_replay();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
